// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM encoding and address helpers for the 2048-point FFT
package fft_pkg;
  localparam int N = 2048;
  localparam int LOG2N = 11;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [LOG2N-1:0] bitrev11(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] y;
    y = '0;
    for (int i = 0; i < LOG2N; i++) y[i] = x[LOG2N-1-i];
    return y;
  endfunction
  function automatic logic [LOG2N-1:0] rotr11(input logic [LOG2N-1:0] x, input int r);
    logic [2*LOG2N-1:0] d;
    d = {x, x} >> r;
    return d[LOG2N-1:0];
  endfunction
endpackage

// File: rtl/fftunload_fifo.sv
// fftunload_fifo: small synchronous FIFO with a combinational head and occupancy count
module fftunload_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  // storage, pointers and occupancy; a simultaneous push and pop keeps the count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp <= nxt(wp);
      end
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fftunload2048.sv
// fftunload2048: streams FFT bins in natural order from the bit-reversed in-place memory
module fftunload2048 import fft_pkg::*; #(
  parameter int DW = 16,
  parameter int RD_LAT = 1,
  parameter int ROT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [LOG2N-1:0]  mem_addr,
  input  logic [2*DW-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_data,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last
);
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW = $clog2(DEPTH+1);
  state_t state, state_n;
  logic [LOG2N:0] cnt;
  logic [LOG2N-1:0] k_q, k_issue;
  logic [RD_LAT-1:0] sr_v;
  logic [RD_LAT-1:0][LOG2N-1:0] sr_k;
  logic [RD_LAT:0] pv;
  logic [RD_LAT:0][LOG2N-1:0] pk;
  logic issue, credit, pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  assign pv = {sr_v, mem_re};
  assign pk = {sr_k, k_q};
  assign busy = state != IDLE;
  assign out_valid = !fifo_empty;
  assign out_last = out_valid && out_index == '1;
  assign pop = out_valid && out_ready;
  assign k_issue = state == IDLE ? '0 : cnt[LOG2N-1:0];
  // every read in flight already owns a FIFO slot, so returns can never be dropped
  assign credit = !(fifo_full && !pop) && ($countones(pv) + int'(fifo_count)) < (DEPTH + int'(pop));
  // next state and read issue; a start coinciding with done is ignored
  always_comb begin
    state_n = state;
    issue = 1'b0;
    unique case (state)
      IDLE: if (start && !done) begin
        state_n = RUN;
        issue = 1'b1;
      end
      RUN: begin
        issue = credit && !cnt[LOG2N];
        if (issue && &cnt[LOG2N-1:0]) state_n = DRAIN;
      end
      DRAIN: if (pop && out_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register and completion pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == DRAIN && pop && out_last;
    end
  end
  // registered read strobe, mapped address and saturating issue counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_re <= 1'b0;
      mem_addr <= '0;
      k_q <= '0;
      cnt <= '0;
    end else begin
      mem_re <= issue;
      if (issue) begin
        mem_addr <= rotr11(bitrev11(k_issue), ROT);
        k_q <= k_issue;
        cnt <= {1'b0, k_issue} + (LOG2N+1)'(1);
      end
    end
  end
  // tag each read with its bin number until the memory data returns
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_v <= '0;
      sr_k <= '0;
    end else begin
      sr_v <= pv[RD_LAT-1:0];
      sr_k <= pk[RD_LAT-1:0];
    end
  end
  fftunload_fifo #(.WIDTH(LOG2N + 2*DW), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(pv[RD_LAT]),
    .wdata({pk[RD_LAT], mem_rdata}),
    .pop(pop),
    .rdata({out_index, out_data}),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule
